// File: rtl/rgb_capture_pkg.sv
// Shared types for the RGB capture path: capture FSM states and pixel formats.
package rgb_capture_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_VBLANK = 2'd1,
    WAIT_FRAME  = 2'd2,
    CAPTURE     = 2'd3
  } cap_state_e;

  // fmt encoding 2'd3 is treated as RGB444 as well.
  typedef enum logic [1:0] {
    FMT_RGB565 = 2'd0,
    FMT_RGB555 = 2'd1,
    FMT_RGB444 = 2'd2
  } pix_fmt_e;

  localparam int PACKED_PIX_W = 16;

endpackage

// File: rtl/rgb_pixel_pack.sv
// Combinational formatter: reduces a 24-bit RGB pixel to the selected 16-bit
// packing, zero-extended to the RAM word width.
module rgb_pixel_pack
  import rgb_capture_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [23:0]       rgb,
  input  logic [1:0]        fmt,
  output logic [DATA_W-1:0] packed_pix
);

  logic [PACKED_PIX_W-1:0] word_s;
  logic                    unused_s;

  // Select the truncation pattern for the active pixel format.
  always_comb begin
    word_s = {PACKED_PIX_W{1'b0}};
    case (fmt)
      FMT_RGB565: word_s = {rgb[23:19], rgb[15:10], rgb[7:3]};
      FMT_RGB555: word_s = {1'b0, rgb[23:19], rgb[15:11], rgb[7:3]};
      default:    word_s = {4'h0, rgb[23:20], rgb[15:12], rgb[7:4]};
    endcase
  end

  // Low bits of each channel never reach RAM in any format.
  assign unused_s   = ^{rgb[18:16], rgb[9:8], rgb[2:0]};
  assign packed_pix = DATA_W'(word_s);

endmodule

// File: rtl/rgb_capture.sv
// Captures a sync-framed RGB pixel stream into a ring of frame slots in RAM,
// discarding short or overlong frames and flagging when enough frames are stored.
module rgb_capture
  import rgb_capture_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH       = 32,
  parameter int RAM_DATA_WIDTH       = 16,
  parameter int IMAGE_WIDTH          = 80,
  parameter int IMAGE_HEIGHT         = 48,
  parameter int IMAGES_IN_RAM        = 3,
  parameter int IMAGES_BEFORE_STREAM = 1
) (
  input  logic                             rgb_clk,
  input  logic                             nrst,
  input  logic [23:0]                      rgb,
  input  logic                             hsync,
  input  logic                             vsync,
  input  logic [1:0]                       fmt,
  input  logic                             rgb_enable,
  output logic [RAM_ADDR_WIDTH-1:0]        ram_addr,
  output logic [RAM_DATA_WIDTH-1:0]        ram_data,
  output logic                             write_enable,
  output logic                             stream_ready,
  output logic                             frame_done,
  output logic                             frame_error,
  output logic [$clog2(IMAGES_IN_RAM)-1:0] frame_slot
);

  localparam int IMAGE_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int SLOT_W     = $clog2(IMAGES_IN_RAM);
  localparam int CNT_W      = $clog2(IMAGE_SIZE + 1);
  localparam int GOOD_W     = $clog2(IMAGES_BEFORE_STREAM + 1);

  cap_state_e                state_q, state_d;
  logic [1:0]                fmt_q, fmt_d;
  logic [SLOT_W-1:0]         slot_q, slot_d;
  logic [SLOT_W-1:0]         frame_slot_q, frame_slot_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      ovf_q, ovf_d;
  logic [GOOD_W-1:0]         good_q, good_d;
  logic                      stream_ready_q, stream_ready_d;
  logic                      frame_done_q, frame_done_d;
  logic                      frame_error_q, frame_error_d;
  logic                      write_enable_q, write_enable_d;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [RAM_DATA_WIDTH-1:0] ram_data_q, ram_data_d;
  logic                      active_s;
  logic [RAM_DATA_WIDTH-1:0] packed_s;

  rgb_pixel_pack #(
    .DATA_W (RAM_DATA_WIDTH)
  ) u_pack (
    .rgb        (rgb),
    .fmt        (fmt_q),
    .packed_pix (packed_s)
  );

  assign active_s = hsync & vsync;

  // Next-state logic for the capture FSM, pixel counter, slot ring and outputs.
  always_comb begin
    state_d        = state_q;
    fmt_d          = fmt_q;
    slot_d         = slot_q;
    frame_slot_d   = frame_slot_q;
    count_d        = count_q;
    ovf_d          = ovf_q;
    good_d         = good_q;
    ram_addr_d     = ram_addr_q;
    ram_data_d     = ram_data_q;
    write_enable_d = 1'b0;
    frame_done_d   = 1'b0;
    frame_error_d  = 1'b0;
    stream_ready_d = stream_ready_q | (good_q == GOOD_W'(IMAGES_BEFORE_STREAM));

    if (!rgb_enable) begin
      // Disable wins over everything; the good-frame tally restarts too so
      // stream_ready cannot re-assert from stale history.
      state_d        = IDLE;
      stream_ready_d = 1'b0;
      slot_d         = {SLOT_W{1'b0}};
      count_d        = {CNT_W{1'b0}};
      ovf_d          = 1'b0;
      good_d         = {GOOD_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT_VBLANK;
        end
        WAIT_VBLANK: begin
          if (!vsync) begin
            state_d = WAIT_FRAME;
          end else begin
            state_d = WAIT_VBLANK;
          end
        end
        WAIT_FRAME: begin
          if (vsync) begin
            state_d = CAPTURE;
            fmt_d   = fmt;
          end else begin
            state_d = WAIT_FRAME;
          end
        end
        CAPTURE: begin
          if (!vsync) begin
            if ((count_q == CNT_W'(IMAGE_SIZE)) && !ovf_q) begin
              frame_done_d = 1'b1;
              frame_slot_d = slot_q;
              if (slot_q == SLOT_W'(IMAGES_IN_RAM - 1)) begin
                slot_d = {SLOT_W{1'b0}};
              end else begin
                slot_d = slot_q + SLOT_W'(1);
              end
              if (good_q != GOOD_W'(IMAGES_BEFORE_STREAM)) begin
                good_d = good_q + GOOD_W'(1);
              end else begin
                good_d = good_q;
              end
            end else begin
              frame_error_d = 1'b1;
            end
            count_d = {CNT_W{1'b0}};
            ovf_d   = 1'b0;
            state_d = WAIT_FRAME;
          end else if (active_s) begin
            if (count_q < CNT_W'(IMAGE_SIZE)) begin
              write_enable_d = 1'b1;
              ram_data_d     = packed_s;
              ram_addr_d     = RAM_ADDR_WIDTH'(slot_q) * RAM_ADDR_WIDTH'(IMAGE_SIZE)
                             + RAM_ADDR_WIDTH'(count_q);
              count_d        = count_q + CNT_W'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end else begin
            state_d = CAPTURE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Register all state and outputs; nrst returns the block to a clean idle.
  always_ff @(posedge rgb_clk or negedge nrst) begin
    if (!nrst) begin
      state_q        <= IDLE;
      fmt_q          <= 2'd0;
      slot_q         <= {SLOT_W{1'b0}};
      frame_slot_q   <= {SLOT_W{1'b0}};
      count_q        <= {CNT_W{1'b0}};
      ovf_q          <= 1'b0;
      good_q         <= {GOOD_W{1'b0}};
      stream_ready_q <= 1'b0;
      frame_done_q   <= 1'b0;
      frame_error_q  <= 1'b0;
      write_enable_q <= 1'b0;
      ram_addr_q     <= {RAM_ADDR_WIDTH{1'b0}};
      ram_data_q     <= {RAM_DATA_WIDTH{1'b0}};
    end else begin
      state_q        <= state_d;
      fmt_q          <= fmt_d;
      slot_q         <= slot_d;
      frame_slot_q   <= frame_slot_d;
      count_q        <= count_d;
      ovf_q          <= ovf_d;
      good_q         <= good_d;
      stream_ready_q <= stream_ready_d;
      frame_done_q   <= frame_done_d;
      frame_error_q  <= frame_error_d;
      write_enable_q <= write_enable_d;
      ram_addr_q     <= ram_addr_d;
      ram_data_q     <= ram_data_d;
    end
  end

  assign ram_addr     = ram_addr_q;
  assign ram_data     = ram_data_q;
  assign write_enable = write_enable_q;
  assign stream_ready = stream_ready_q;
  assign frame_done   = frame_done_q;
  assign frame_error  = frame_error_q;
  assign frame_slot   = frame_slot_q;

endmodule
